// File: rtl/prog_count_pkg.sv
// prog_count_pkg: shared state enum and sizing constants for the prog_count family
package prog_count_pkg;
  localparam int CNT_W = 7;
  localparam int MAX_VAL = 99;
  typedef enum logic [1:0] {IDLE, COUNTING, PAUSED, EXPIRED} state_t;
endpackage

// File: rtl/bin2bcd_7.sv
// bin2bcd_7: combinational double-dabble binary to BCD tens/ones converter
// Ports: bin (7-bit binary in), tens/ones (BCD digits out; hundreds dropped, caller keeps bin <= 99)
module bin2bcd_7 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [18:0] s;
  always_comb begin
    s = {12'd0, bin};
    for (int i = 0; i < 7; i++) begin
      if (s[10:7] >= 4'd5) s[10:7] = s[10:7] + 4'd3;
      if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
      s = s << 1;
    end
    tens = s[14:11];
    ones = s[10:7];
  end
endmodule

// File: rtl/prog_countdown_7.sv
// prog_countdown_7: loadable 0..MAX_VAL down-counter with paired binary/BCD count and one-cycle done pulse
// Ports: CLK, RST_N (async active-low); load/load_value preset; run level enable; tick count strobe;
//        count_out, bcd_tens, bcd_ones, done registered; busy, zero decoded from registers
module prog_countdown_7 #(
  parameter int MAX_VAL = prog_count_pkg::MAX_VAL
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             load,
  input  logic [prog_count_pkg::CNT_W-1:0] load_value,
  input  logic                             run,
  input  logic                             tick,
  output logic [prog_count_pkg::CNT_W-1:0] count_out,
  output logic [3:0]                       bcd_tens,
  output logic [3:0]                       bcd_ones,
  output logic                             busy,
  output logic                             zero,
  output logic                             done
);
  import prog_count_pkg::*;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);
  state_t state, state_n;
  logic [CNT_W-1:0] load_c, cnt_n;
  logic [3:0] ld_tens, ld_ones, tens_n, ones_n;
  logic done_n;
  assign load_c = load_value > MAX_C ? MAX_C : load_value;
  assign busy = state == COUNTING || state == PAUSED;
  assign zero = count_out == '0;
  bin2bcd_7 u_bin2bcd (.bin(load_c), .tens(ld_tens), .ones(ld_ones));
  always_comb begin
    state_n = state;
    cnt_n = count_out;
    tens_n = bcd_tens;
    ones_n = bcd_ones;
    done_n = 1'b0;
    if (load) begin
      state_n = IDLE;
      cnt_n = load_c;
      tens_n = ld_tens;
      ones_n = ld_ones;
    end else begin
      case (state)
        IDLE: if (run) begin
          state_n = zero ? EXPIRED : COUNTING;
          done_n = zero;
        end
        COUNTING: if (!run) state_n = PAUSED;
          else if (tick) begin
            cnt_n = count_out - 1'b1;
            ones_n = bcd_ones == 4'd0 ? 4'd9 : bcd_ones - 4'd1;
            tens_n = bcd_ones == 4'd0 ? bcd_tens - 4'd1 : bcd_tens;
            state_n = count_out == CNT_W'(1) ? EXPIRED : COUNTING;
            done_n = count_out == CNT_W'(1);
          end
        PAUSED: if (run) state_n = COUNTING;
        default: ;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      count_out <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      count_out <= cnt_n;
      bcd_tens <= tens_n;
      bcd_ones <= ones_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_prog_countdown_7.sv
// tb_prog_countdown_7: self-checking bench for prog_countdown_7 against a behavioural countdown model
module tb_prog_countdown_7;
  logic CLK = 1'b0, RST_N = 1'b0, load = 1'b0, run = 1'b0, tick = 1'b0;
  logic [6:0] load_value = '0;
  logic [6:0] count_out;
  logic [3:0] bcd_tens, bcd_ones;
  logic busy, zero, done;
  logic [17:0] got;
  int total = 0, bad = 0;
  int m_cnt = 0;
  int m_ph = 0;
  bit m_done = 0;

  prog_countdown_7 dut (
    .CLK(CLK), .RST_N(RST_N), .load(load), .load_value(load_value), .run(run), .tick(tick),
    .count_out(count_out), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .busy(busy), .zero(zero), .done(done)
  );

  always #5 CLK = ~CLK;
  assign got = {count_out, bcd_tens, bcd_ones, busy, zero, done};

  // model phases: 0 idle, 1 counting, 2 paused, 3 expired
  function automatic void model(bit l, int lv, bit r, bit t);
    m_done = 0;
    if (l) begin
      m_cnt = lv > 99 ? 99 : lv;
      m_ph = 0;
    end else if (m_ph == 0 && r) begin
      m_ph = m_cnt == 0 ? 3 : 1;
      m_done = m_cnt == 0;
    end else if (m_ph == 1 && !r) m_ph = 2;
    else if (m_ph == 1 && t) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_ph = 3;
        m_done = 1;
      end
    end else if (m_ph == 2 && r) m_ph = 1;
  endfunction

  function automatic logic [17:0] exp_vec();
    return {7'(m_cnt), 4'(m_cnt / 10), 4'(m_cnt % 10), m_ph == 1 || m_ph == 2, m_cnt == 0, m_done};
  endfunction

  task automatic cyc(bit l, int lv, bit r, bit t);
    load = l;
    load_value = 7'(lv);
    run = r;
    tick = t;
    @(posedge CLK);
    model(l, lv, r, t);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (got !== 18'h2) begin bad++; $display("FAIL reset_init got=%h exp=%h", got, 18'h2); end
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(1, 42, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);
    total++;
    if (got !== exp_vec() || count_out !== 7'd37) begin bad++; $display("FAIL reset_precount got=%h exp=%h", got, exp_vec()); end
    #2;
    RST_N = 1'b0;
    m_cnt = 0; m_ph = 0; m_done = 0;
    #1;
    total++;
    if (got !== 18'h2) begin bad++; $display("FAIL reset_async got=%h exp=%h", got, 18'h2); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_countdown();
    int dones = 0;
    cyc(1, 12, 0, 0);
    total++;
    if (got !== exp_vec() || bcd_tens !== 4'd1 || bcd_ones !== 4'd2) begin bad++; $display("FAIL load12 got=%h exp=%h", got, exp_vec()); end
    for (int i = 0; i < 18; i++) begin
      cyc(0, 0, 1, 1);
      dones += done;
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL countdown cyc=%0d got=%h exp=%h", i, got, exp_vec()); end
    end
    total++;
    if (dones !== 1 || count_out !== 7'd0 || busy !== 1'b0) begin bad++; $display("FAIL countdown_end dones=%0d cnt=%0d exp dones=1 cnt=0", dones, count_out); end
  endtask

  task automatic test_clamp_zero();
    int busies = 0, dones = 0;
    cyc(1, 120, 0, 0);
    total++;
    if (count_out !== 7'd99 || bcd_tens !== 4'd9 || bcd_ones !== 4'd9) begin bad++; $display("FAIL clamp got=%0d %0d/%0d exp=99 9/9", count_out, bcd_tens, bcd_ones); end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1);
      busies += busy;
      dones += done;
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL zero_run cyc=%0d got=%h exp=%h", i, got, exp_vec()); end
    end
    total++;
    if (busies !== 0 || dones !== 1) begin bad++; $display("FAIL zero_run_pulse busy=%0d done=%0d exp busy=0 done=1", busies, dones); end
  endtask

  task automatic test_pause();
    cyc(1, 30, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);
    total++;
    if (count_out !== 7'd27) begin bad++; $display("FAIL pause_pre got=%0d exp=27", count_out); end
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    total++;
    if (got !== exp_vec() || count_out !== 7'd27 || busy !== 1'b1) begin bad++; $display("FAIL pause_hold got=%h exp=%h", got, exp_vec()); end
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    total++;
    if (got !== exp_vec() || count_out !== 7'd26) begin bad++; $display("FAIL pause_resume got=%h exp=%h", got, exp_vec()); end
  endtask

  task automatic test_priority();
    cyc(1, 3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
    total++;
    if (count_out !== 7'd1) begin bad++; $display("FAIL prio_pre got=%0d exp=1", count_out); end
    cyc(1, 55, 1, 1);
    total++;
    if (got !== exp_vec() || count_out !== 7'd55 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL prio_load got=%h exp=%h", got, exp_vec()); end
    cyc(0, 0, 0, 1);
    total++;
    if (done !== 1'b0 || count_out !== 7'd55) begin bad++; $display("FAIL prio_after done=%b cnt=%0d exp done=0 cnt=55", done, count_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(15) == 0, $urandom_range(127), $urandom_range(7) != 0, $urandom_range(3) != 0);
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_vec()); end
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_countdown();
    test_clamp_zero();
    test_pause();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
